// File: rtl/tlb_ptw.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tlb_ptw : Sv39 page-table walker and PTE write-through engine for the TLB.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tlb_ptw (
   input  logic        clk,
   input  logic        rst,
   input  logic [43:0] satp_ppn,
   input  logic        translate_req,
   input  logic        write_through_req,
   input  logic        tsl_read,
   input  logic        tsl_write,
   input  logic        tsl_execute,
   input  logic [63:0] pte_pa_va_in,
   input  logic [63:0] pte_in,
   output logic [43:0] PPN_in,
   output logic [63:0] PTE_in,
   output logic [63:0] PTE_pa_in,
   output logic        ready,
   output logic        entry_write,
   output logic        TLB_D_set,
   output logic        page_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EVAL   = 3'd2,
      S_UPDATE = 3'd3,
      S_DONE   = 3'd4,
      S_FAULT  = 3'd5,
      S_WT     = 3'd6
   } state_t;

   state_t      state_q;
   logic [1:0]  level_q;
   logic [43:0] base_q;
   logic [38:12] va_q;
   logic        write_q;
   logic        wt_q;
   logic        skip_q;
   logic [63:0] pte_q;
   logic [63:0] pte_pa_q;
   logic [43:0] ppn_q;

   logic        w_active_req;
   logic        w_noncanon;
   logic        w_leaf;
   logic        w_fault;
   logic        w_need_upd;
   logic [63:0] w_pte_upd;
   logic [43:0] w_leaf_ppn;
   logic        w_unused_access;

   function automatic logic [63:0] walk_addr(input logic [43:0] base,
                                             input logic [1:0]  lvl,
                                             input logic [26:0] vpns);
      logic [8:0] vpn;
      case (lvl)
         2'd2:    vpn = vpns[26:18];
         2'd1:    vpn = vpns[17:9];
         default: vpn = vpns[8:0];
      endcase
      return {8'd0, base, vpn, 3'b000};
   endfunction

   assign w_unused_access = tsl_read | tsl_execute;
   assign w_active_req    = wt_q ? write_through_req : translate_req;
   assign w_noncanon      = pte_pa_va_in[63:39] != {25{pte_pa_va_in[38]}};
   assign w_leaf          = pte_q[1] | pte_q[3];
   assign w_fault         = !pte_q[0] || (!pte_q[1] && pte_q[2])
                         || (!w_leaf && level_q == 2'd0)
                         || (w_leaf && level_q == 2'd2 && pte_q[27:10] != 18'd0)
                         || (w_leaf && level_q == 2'd1 && pte_q[18:10] != 9'd0);
   assign w_need_upd      = !pte_q[6] || (write_q && !pte_q[7]);
   assign w_pte_upd       = pte_q | {56'd0, write_q, 1'b1, 6'd0};

   // Superpages splice the untranslated VPN bits into the low PPN.
   always_comb begin
      w_leaf_ppn = pte_q[53:10];
      case (level_q)
         2'd2:    w_leaf_ppn = {pte_q[53:28], va_q[38:21]};
         2'd1:    w_leaf_ppn = {pte_q[53:19], va_q[20:12]};
         default: w_leaf_ppn = pte_q[53:10];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         level_q     <= 2'd0;
         base_q      <= 44'd0;
         va_q        <= '0;
         write_q     <= 1'b0;
         wt_q        <= 1'b0;
         skip_q      <= 1'b0;
         pte_q       <= 64'd0;
         pte_pa_q    <= 64'd0;
         ppn_q       <= 44'd0;
         PPN_in      <= 44'd0;
         PTE_in      <= 64'd0;
         PTE_pa_in   <= 64'd0;
         ready       <= 1'b0;
         entry_write <= 1'b0;
         TLB_D_set   <= 1'b0;
         page_fault  <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 64'd0;
         mem_wdata   <= 64'd0;
      end else begin
         ready       <= 1'b0;
         entry_write <= 1'b0;
         TLB_D_set   <= 1'b0;
         page_fault  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // The cycle after a response pulse ignores a still-held request.
               if (skip_q) begin
                  skip_q <= 1'b0;
               end else if (write_through_req) begin
                  wt_q      <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= pte_pa_va_in;
                  mem_wdata <= pte_in | 64'hC0;
                  state_q   <= S_WT;
               end else if (translate_req) begin
                  wt_q    <= 1'b0;
                  va_q    <= pte_pa_va_in[38:12];
                  write_q <= tsl_write;
                  level_q <= 2'd2;
                  base_q  <= satp_ppn;
                  if (w_noncanon) begin
                     page_fault <= 1'b1;
                     state_q    <= S_FAULT;
                  end else begin
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= walk_addr(satp_ppn, 2'd2, pte_pa_va_in[38:12]);
                     state_q  <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  pte_q    <= mem_rdata;
                  pte_pa_q <= mem_addr;
                  state_q  <= w_active_req ? S_EVAL : S_IDLE;
               end
            end
            S_EVAL: begin
               if (!w_active_req) begin
                  state_q <= S_IDLE;
               end else if (w_fault) begin
                  page_fault <= 1'b1;
                  state_q    <= S_FAULT;
               end else if (!w_leaf) begin
                  base_q   <= pte_q[53:10];
                  level_q  <= level_q - 2'd1;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= walk_addr(pte_q[53:10], level_q - 2'd1, va_q);
                  state_q  <= S_FETCH;
               end else if (w_need_upd) begin
                  pte_q     <= w_pte_upd;
                  ppn_q     <= w_leaf_ppn;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= pte_pa_q;
                  mem_wdata <= w_pte_upd;
                  state_q   <= S_UPDATE;
               end else begin
                  ready       <= 1'b1;
                  entry_write <= 1'b1;
                  PPN_in      <= w_leaf_ppn;
                  PTE_in      <= pte_q;
                  PTE_pa_in   <= pte_pa_q;
                  state_q     <= S_DONE;
               end
            end
            S_UPDATE: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (w_active_req) begin
                     ready       <= 1'b1;
                     entry_write <= 1'b1;
                     PPN_in      <= ppn_q;
                     PTE_in      <= pte_q;
                     PTE_pa_in   <= pte_pa_q;
                     state_q     <= S_DONE;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_WT: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (w_active_req) begin
                     ready     <= 1'b1;
                     TLB_D_set <= 1'b1;
                     state_q   <= S_DONE;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_DONE, S_FAULT: begin
               skip_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tlb_ptw.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_tlb_ptw : directed self-checking bench for the tlb_ptw walker.           |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_tlb_ptw;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [43:0] satp_ppn = 44'h100;
   logic        translate_req = 1'b0;
   logic        write_through_req = 1'b0;
   logic        tsl_read = 1'b0;
   logic        tsl_write = 1'b0;
   logic        tsl_execute = 1'b0;
   logic [63:0] pte_pa_va_in = 64'd0;
   logic [63:0] pte_in = 64'd0;
   logic [43:0] PPN_in;
   logic [63:0] PTE_in;
   logic [63:0] PTE_pa_in;
   logic        ready;
   logic        entry_write;
   logic        TLB_D_set;
   logic        page_fault;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata = 64'd0;
   logic        mem_ack = 1'b0;

   int errors = 0;
   int checks = 0;

   tlb_ptw dut (
      .clk(clk), .rst(rst), .satp_ppn(satp_ppn),
      .translate_req(translate_req), .write_through_req(write_through_req),
      .tsl_read(tsl_read), .tsl_write(tsl_write), .tsl_execute(tsl_execute),
      .pte_pa_va_in(pte_pa_va_in), .pte_in(pte_in),
      .PPN_in(PPN_in), .PTE_in(PTE_in), .PTE_pa_in(PTE_pa_in),
      .ready(ready), .entry_write(entry_write), .TLB_D_set(TLB_D_set),
      .page_fault(page_fault), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   // Memory model: acks on the falling edge once ack_delay waiting cycles elapse.
   logic [63:0] mem [logic [63:0]];
   logic [63:0] log_addr[$];
   logic        log_we[$];
   logic [63:0] log_wdata[$];
   int ack_delay = 0;
   int wcnt = 0;
   int mreq_cnt = 0;

   always @(negedge clk) begin
      if (mem_req) begin
         mreq_cnt = mreq_cnt + 1;
         if (wcnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 64'd0;
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_wdata.push_back(mem_wdata);
            if (mem_we) mem[mem_addr] = mem_wdata;
            wcnt = 0;
         end else begin
            mem_ack = 1'b0;
            wcnt    = wcnt + 1;
         end
      end else begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end
   end

   int r_rdy_c, r_rdy_l, r_pf_c, r_dset_c, r_n_rdy, r_n_pf, r_n_ew, r_n_dset;

   // Raises a request in cycle 0 and records response pulses per cycle.
   task automatic run_req(input logic do_tr, input logic do_wt, input logic [63:0] va_pa,
                          input logic [63:0] pte, input logic wr, input int hold, input int obs);
      repeat (3) @(posedge clk);
      #1;
      log_addr.delete(); log_we.delete(); log_wdata.delete();
      mreq_cnt = 0;
      r_rdy_c = -1; r_rdy_l = -1; r_pf_c = -1; r_dset_c = -1;
      r_n_rdy = 0; r_n_pf = 0; r_n_ew = 0; r_n_dset = 0;
      pte_pa_va_in = va_pa;
      pte_in = pte;
      tsl_write = wr;
      tsl_read = !wr;
      translate_req = do_tr;
      write_through_req = do_wt;
      for (int k = 0; k < obs; k++) begin
         @(negedge clk);
         if (ready) begin
            r_n_rdy++;
            if (r_rdy_c < 0) r_rdy_c = k;
            r_rdy_l = k;
         end
         if (page_fault) begin
            r_n_pf++;
            if (r_pf_c < 0) r_pf_c = k;
         end
         if (entry_write) r_n_ew++;
         if (TLB_D_set) begin
            r_n_dset++;
            if (r_dset_c < 0) r_dset_c = k;
         end
         if ((hold == 0 && (ready || page_fault)) || (hold > 0 && k + 1 == hold)) begin
            translate_req = 1'b0;
            write_through_req = 1'b0;
         end
      end
      translate_req = 1'b0;
      write_through_req = 1'b0;
   endtask

   task automatic load_walk3();
      mem[64'h100000] = 64'h80001;
      mem[64'h200010] = 64'hC0001;
      mem[64'h300010] = 64'h48D1443;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ready, entry_write, TLB_D_set, page_fault, mem_req, mem_we} !== 6'b0)
         begin errors++; $display("FAIL reset_ctrl: got %b expected 000000",
            {ready, entry_write, TLB_D_set, page_fault, mem_req, mem_we}); end
      checks++;
      if ({mem_addr, mem_wdata, PPN_in, PTE_in, PTE_pa_in} !== '0)
         begin errors++; $display("FAIL reset_data: got addr=%h ppn=%h pte=%h expected all zero",
            mem_addr, PPN_in, PTE_in); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_walk3();
      ack_delay = 0;
      load_walk3();
      run_req(1'b1, 1'b0, 64'h0040_2000, 64'd0, 1'b0, 0, 12);
      checks++;
      if (r_rdy_c !== 7) begin errors++; $display("FAIL walk3_latency: got %0d expected 7", r_rdy_c); end
      checks++;
      if (r_n_ew !== 1) begin errors++; $display("FAIL walk3_entry_write: got %0d expected 1", r_n_ew); end
      checks++;
      if (PPN_in !== 44'h12345) begin errors++; $display("FAIL walk3_ppn: got %h expected 12345", PPN_in); end
      checks++;
      if (PTE_in !== 64'h48D1443) begin errors++; $display("FAIL walk3_pte: got %h expected 48d1443", PTE_in); end
      checks++;
      if (PTE_pa_in !== 64'h300010) begin errors++; $display("FAIL walk3_pte_pa: got %h expected 300010", PTE_pa_in); end
      checks++;
      if (log_addr.size() !== 3) begin
         errors++; $display("FAIL walk3_nreads: got %0d expected 3", log_addr.size());
      end else begin
         checks++;
         if ({log_addr[0], log_addr[1], log_addr[2]} !== {64'h100000, 64'h200010, 64'h300010}
             || {log_we[0], log_we[1], log_we[2]} !== 3'b000)
            begin errors++; $display("FAIL walk3_addrs: got %h %h %h we=%b%b%b expected 100000 200010 300010 reads",
               log_addr[0], log_addr[1], log_addr[2], log_we[0], log_we[1], log_we[2]); end
      end
   endtask

   task automatic test_superpage();
      ack_delay = 0;
      mem[64'h100000] = 64'h80001;
      mem[64'h200010] = 64'h1004C3;
      run_req(1'b1, 1'b0, 64'h0040_5000, 64'd0, 1'b0, 0, 10);
      checks++;
      if (r_pf_c !== 5 || r_n_ew !== 0 || r_n_rdy !== 0)
         begin errors++; $display("FAIL super_misalign: got pf_cycle=%0d ew=%0d rdy=%0d expected 5 0 0",
            r_pf_c, r_n_ew, r_n_rdy); end
      checks++;
      if (PPN_in !== 44'h12345) begin errors++; $display("FAIL super_hold: got %h expected 12345", PPN_in); end
      mem[64'h200010] = 64'h1000C3;
      run_req(1'b1, 1'b0, 64'h0040_5000, 64'd0, 1'b0, 0, 10);
      checks++;
      if (r_rdy_c !== 5 || r_n_pf !== 0) begin errors++; $display("FAIL super_latency: got %0d pf=%0d expected 5 0", r_rdy_c, r_n_pf); end
      checks++;
      if (PPN_in !== 44'h405) begin errors++; $display("FAIL super_ppn: got %h expected 405", PPN_in); end
      checks++;
      if (PTE_pa_in !== 64'h200010) begin errors++; $display("FAIL super_pte_pa: got %h expected 200010", PTE_pa_in); end
   endtask

   task automatic test_write_update();
      ack_delay = 0;
      mem[64'h100008] = 64'h10000007;
      run_req(1'b1, 1'b0, 64'h4000_0000, 64'd0, 1'b1, 0, 10);
      checks++;
      if (r_rdy_c !== 4 || r_n_ew !== 1) begin errors++; $display("FAIL upd_latency: got %0d ew=%0d expected 4 1", r_rdy_c, r_n_ew); end
      checks++;
      if (log_addr.size() !== 2) begin
         errors++; $display("FAIL upd_ntrans: got %0d expected 2", log_addr.size());
      end else if (log_we[1] !== 1'b1 || log_addr[1] !== 64'h100008 || log_wdata[1] !== 64'h100000C7) begin
         errors++; $display("FAIL upd_write: got we=%b addr=%h data=%h expected 1 100008 100000c7",
            log_we[1], log_addr[1], log_wdata[1]);
      end
      checks++;
      if (PTE_in !== 64'h100000C7) begin errors++; $display("FAIL upd_pte: got %h expected 100000c7", PTE_in); end
      checks++;
      if (PPN_in !== 44'h40200) begin errors++; $display("FAIL upd_ppn: got %h expected 40200", PPN_in); end
   endtask

   task automatic test_write_through();
      ack_delay = 0;
      run_req(1'b1, 1'b1, 64'h8000_1008, 64'h1234_504F, 1'b1, 0, 8);
      checks++;
      if (r_rdy_c !== 2 || r_dset_c !== 2 || r_n_ew !== 0)
         begin errors++; $display("FAIL wt_pulses: got rdy=%0d dset=%0d ew=%0d expected 2 2 0",
            r_rdy_c, r_dset_c, r_n_ew); end
      checks++;
      if (log_addr.size() !== 1) begin
         errors++; $display("FAIL wt_ntrans: got %0d expected 1", log_addr.size());
      end else if (log_we[0] !== 1'b1 || log_addr[0] !== 64'h8000_1008 || log_wdata[0] !== 64'h1234_50CF) begin
         errors++; $display("FAIL wt_write: got we=%b addr=%h data=%h expected 1 80001008 123450cf",
            log_we[0], log_addr[0], log_wdata[0]);
      end
      checks++;
      if (PPN_in !== 44'h40200) begin errors++; $display("FAIL wt_hold: got %h expected 40200", PPN_in); end
   endtask

   task automatic test_noncanonical();
      run_req(1'b1, 1'b0, 64'h0000_0080_0000_0000, 64'd0, 1'b0, 0, 6);
      checks++;
      if (r_pf_c !== 1 || r_n_rdy !== 0 || r_n_ew !== 0)
         begin errors++; $display("FAIL noncanon_fault: got pf=%0d rdy=%0d ew=%0d expected 1 0 0",
            r_pf_c, r_n_rdy, r_n_ew); end
      checks++;
      if (mreq_cnt !== 0) begin errors++; $display("FAIL noncanon_memreq: got %0d expected 0", mreq_cnt); end
   endtask

   task automatic test_withdraw();
      ack_delay = 5;
      load_walk3();
      run_req(1'b1, 1'b0, 64'h0040_2000, 64'd0, 1'b0, 2, 15);
      checks++;
      if (r_n_rdy !== 0 || r_n_pf !== 0 || r_n_ew !== 0)
         begin errors++; $display("FAIL withdraw_pulses: got rdy=%0d pf=%0d ew=%0d expected 0 0 0",
            r_n_rdy, r_n_pf, r_n_ew); end
      checks++;
      if (log_addr.size() !== 1 || mreq_cnt !== 6)
         begin errors++; $display("FAIL withdraw_mem: got trans=%0d req_cycles=%0d expected 1 6",
            log_addr.size(), mreq_cnt); end
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL withdraw_idle: got mem_req=%b expected 0", mem_req); end
      ack_delay = 0;
   endtask

   task automatic test_back_to_back();
      ack_delay = 0;
      run_req(1'b1, 1'b0, 64'h4000_0000, 64'd0, 1'b0, 12, 12);
      checks++;
      if (r_n_rdy !== 2 || r_rdy_c !== 3 || r_rdy_l !== 8)
         begin errors++; $display("FAIL b2b_ready: got n=%0d first=%0d last=%0d expected 2 3 8",
            r_n_rdy, r_rdy_c, r_rdy_l); end
      checks++;
      if (PTE_in !== 64'h100000C7 || PPN_in !== 44'h40200)
         begin errors++; $display("FAIL b2b_entry: got pte=%h ppn=%h expected 100000c7 40200", PTE_in, PPN_in); end
   endtask

   task automatic test_reset_midwalk();
      ack_delay = 0;
      load_walk3();
      repeat (3) @(posedge clk);
      #1;
      pte_pa_va_in = 64'h0040_2000;
      tsl_write = 1'b0;
      translate_req = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ready, entry_write, TLB_D_set, page_fault, mem_req, mem_we} !== 6'b0
          || {mem_addr, mem_wdata, PPN_in, PTE_in, PTE_pa_in} !== '0)
         begin errors++; $display("FAIL midwalk_reset: got ctrl=%b addr=%h ppn=%h pte=%h expected all zero",
            {ready, entry_write, TLB_D_set, page_fault, mem_req, mem_we}, mem_addr, PPN_in, PTE_in); end
      translate_req = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_walk3();
      test_superpage();
      test_write_update();
      test_write_through();
      test_noncanonical();
      test_withdraw();
      test_back_to_back();
      test_reset_midwalk();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
